// File: rtl/exu_mdu_ctrl.sv
// exu_mdu_ctrl: multi-cycle sequencer for the RV32M multiply/divide path.
// Takes one M-extension op from E-pipe, iterates a shared shift-add /
// restoring-subtract datapath one bit per cycle, and hands the result to
// M-pipe over a valid/ready handshake. E-pipe is stalled while busy.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   E_valid_i  E-pipe holds a valid MDU op
//   e_ready_o  op can be accepted this cycle
//   e_valid_o  result valid to M-pipe
//   M_ready_i  M-pipe accepts the result
//   flush_i    kill the in-flight op
//   funct3_i   000 mul, 001 mulh, 010 mulhsu, 011 mulhu,
//              100 div, 101 divu, 110 rem, 111 remu
//   src1_i     rs1 operand
//   src2_i     rs2 operand
//   res_o      result, held while e_valid_o=1
//   busy_o     state != IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an op; e_ready_o=1
// CALC  | one multiply/divide iteration per cycle, cnt 0..XLEN-1
// FIX   | sign correction and result-word select into res_o
// DONE  | e_valid_o=1, result held until M_ready_i

module exu_mdu_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            E_valid_i,
  output logic            e_ready_o,
  output logic            e_valid_o,
  input  logic            M_ready_i,
  input  logic            flush_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  output logic [XLEN-1:0] res_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       op_q;
  logic             res_neg_q;
  logic [XLEN-1:0]  acc_hi_q, acc_lo_q, opb_q;

  // capture-side decode
  logic            accept;
  logic            is_div;
  logic            a_signed, b_signed;
  logic            s1, s2;
  logic [XLEN-1:0] mag1, mag2;
  logic            div_by_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;
  logic            res_neg;

  // iteration datapath
  logic [XLEN-1:0]   mul_addend;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic              div_ge;
  logic [XLEN-1:0]   div_diff;

  // result correction
  logic [2*XLEN-1:0] prod, prod_c;
  logic [XLEN-1:0]   quo_c, rem_c;
  logic [XLEN-1:0]   fix_res;

  assign accept = (state_q == IDLE) && E_valid_i && !flush_i;
  assign is_div = funct3_i[2];

  // mulh: both signed; mulhsu: rs1 only; div/rem: both
  assign a_signed = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                    (funct3_i == 3'b100) || (funct3_i == 3'b110);
  assign b_signed = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                    (funct3_i == 3'b110);

  assign s1   = a_signed && src1_i[XLEN-1];
  assign s2   = b_signed && src2_i[XLEN-1];
  assign mag1 = s1 ? (~src1_i + 1'b1) : src1_i;
  assign mag2 = s2 ? (~src2_i + 1'b1) : src2_i;

  assign div_by_zero = is_div && (src2_i == '0);
  assign div_ovf     = is_div && !funct3_i[0] &&
                       (src1_i == {1'b1, {(XLEN-1){1'b0}}}) && (src2_i == '1);
  assign special     = div_by_zero || div_ovf;

  always_comb begin
    special_res = '0;
    if (div_by_zero)
      special_res = funct3_i[1] ? src1_i : '1;
    else
      special_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // remainder follows the dividend, everything else takes s1 ^ s2
  assign res_neg = (funct3_i[2] && funct3_i[1]) ? s1 : (s1 ^ s2);

  // multiply: {acc_hi, acc_lo} shifts right, multiplier starts in acc_lo
  assign mul_addend = acc_lo_q[0] ? opb_q : '0;
  assign mul_sum    = {1'b0, acc_hi_q} + {1'b0, mul_addend};

  // divide: partial remainder in acc_hi, dividend shifts out of acc_lo MSB
  // while quotient bits shift in at the LSB. The partial remainder stays
  // below the divisor, so the difference fits in XLEN bits when taken.
  assign div_shift = {acc_hi_q, acc_lo_q[XLEN-1]};
  assign div_ge    = div_shift >= {1'b0, opb_q};
  assign div_diff  = div_shift[XLEN-1:0] - opb_q;

  assign prod   = {acc_hi_q, acc_lo_q};
  assign prod_c = res_neg_q ? (~prod + 1'b1) : prod;
  assign quo_c  = res_neg_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
  assign rem_c  = res_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:                 fix_res = prod_c[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_c[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = quo_c;
      default:                fix_res = rem_c;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = special ? DONE : CALC;
      CALC: if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: if (M_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  // outputs
  always_comb begin
    e_ready_o = 1'b0;
    e_valid_o = 1'b0;
    busy_o    = 1'b1;
    case (state_q)
      IDLE: begin
        e_ready_o = 1'b1;
        busy_o    = 1'b0;
      end
      DONE:    e_valid_o = 1'b1;
      default: ;
    endcase
  end

  // datapath and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      op_q      <= '0;
      res_neg_q <= 1'b0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      opb_q     <= '0;
      res_o     <= '0;
    end else begin
      if (flush_i || accept)
        cnt_q <= '0;
      else if (state_q == CALC)
        cnt_q <= cnt_q + 1'b1;

      if (accept) begin
        op_q      <= funct3_i;
        res_neg_q <= res_neg;
        acc_hi_q  <= '0;
        acc_lo_q  <= is_div ? mag1 : mag2;
        opb_q     <= is_div ? mag2 : mag1;
        if (special) res_o <= special_res;
      end else if (state_q == CALC) begin
        if (op_q[2]) begin
          acc_hi_q <= div_ge ? div_diff : div_shift[XLEN-1:0];
          acc_lo_q <= {acc_lo_q[XLEN-2:0], div_ge};
        end else begin
          acc_hi_q <= mul_sum[XLEN:1];
          acc_lo_q <= {mul_sum[0], acc_lo_q[XLEN-1:1]};
        end
      end else if (state_q == FIX) begin
        res_o <= fix_res;
      end
    end
  end

endmodule

// File: tb/tb_exu_mdu_ctrl.sv
module tb_exu_mdu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        E_valid_i;
  logic        e_ready_o;
  logic        e_valid_o;
  logic        M_ready_i;
  logic        flush_i;
  logic [2:0]  funct3_i;
  logic [31:0] src1_i;
  logic [31:0] src2_i;
  logic [31:0] res_o;
  logic        busy_o;

  int n_cmp = 0;
  int n_err = 0;

  exu_mdu_ctrl #(.XLEN(32), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .E_valid_i (E_valid_i),
    .e_ready_o (e_ready_o),
    .e_valid_o (e_valid_o),
    .M_ready_i (M_ready_i),
    .flush_i   (flush_i),
    .funct3_i  (funct3_i),
    .src1_i    (src1_i),
    .src2_i    (src2_i),
    .res_o     (res_o),
    .busy_o    (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RV32M semantics computed with plain wide arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    int              ia, ib;
    logic            ovf;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin up = ua * ub; return up[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // Issue one op from IDLE, check latency, stall, result, hold and handoff.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    int          edges;
    int          stall_bad;
    int          exp_lat;
    logic [31:0] exp_res;
    exp_res = ref_model(f, a, b);
    exp_lat = is_special(f, a, b) ? 1 : 34;
    check({tag, ":ready_idle"}, 32'(e_ready_o), 32'd1);
    E_valid_i = 1'b1;
    funct3_i  = f;
    src1_i    = a;
    src2_i    = b;
    tick();
    E_valid_i = 1'b0;
    src1_i    = $urandom;
    src2_i    = $urandom;
    edges     = 1;
    stall_bad = 0;
    while (!e_valid_o && edges < 80) begin
      if (e_ready_o !== 1'b0) stall_bad++;
      tick();
      edges++;
    end
    check({tag, ":valid"}, 32'(e_valid_o), 32'd1);
    check({tag, ":latency"}, 32'(edges), 32'(exp_lat));
    check({tag, ":stall"}, 32'(stall_bad), 32'd0);
    check({tag, ":res"}, res_o, exp_res);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ":hold_valid"}, 32'(e_valid_o), 32'd1);
      check({tag, ":hold_res"}, res_o, exp_res);
    end
    check({tag, ":ready_done"}, 32'(e_ready_o), 32'd0);
    M_ready_i = 1'b1;
    tick();
    M_ready_i = 1'b0;
    check({tag, ":valid_drop"}, 32'(e_valid_o), 32'd0);
    check({tag, ":ready_back"}, 32'(e_ready_o), 32'd1);
  endtask

  initial begin
    int        seen_valid;
    logic [2:0] rf;
    rst_n     = 1'b0;
    E_valid_i = 1'b0;
    M_ready_i = 1'b0;
    flush_i   = 1'b0;
    funct3_i  = 3'b000;
    src1_i    = '0;
    src2_i    = '0;
    #12;
    check("rst_ready", 32'(e_ready_o), 32'd1);
    check("rst_valid", 32'(e_valid_o), 32'd0);
    check("rst_res", res_o, 32'h0);
    check("rst_busy", 32'(busy_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("mulhu_ff", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op("mulh_m2x3", 3'b001, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("mul_m2x3", 3'b000, 32'hFFFF_FFFE, 32'd3, 0);
    run_op("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_by0", 3'b101, 32'd5, 32'd0, 0);
    run_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("remu_by0", 3'b111, 32'h1234_5678, 32'd0, 0);
    run_op("mulhsu_bp", 3'b010, 32'h8000_0001, 32'hFFFF_FFF0, 10);

    // flush at cnt=10 during a divide
    E_valid_i = 1'b1; funct3_i = 3'b100; src1_i = 32'd1000; src2_i = 32'd7;
    tick();
    E_valid_i = 1'b0;
    repeat (10) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_ready", 32'(e_ready_o), 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      if (e_valid_o !== 1'b0) seen_valid++;
      tick();
    end
    check("flush_no_valid", 32'(seen_valid), 32'd0);
    run_op("after_flush", 3'b101, 32'd1000, 32'd7, 0);

    // reset mid-CALC
    E_valid_i = 1'b1; funct3_i = 3'b000; src1_i = 32'd12345; src2_i = 32'd678;
    tick();
    E_valid_i = 1'b0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_valid", 32'(e_valid_o), 32'd0);
    check("mid_rst_res", res_o, 32'h0);
    check("mid_rst_ready", 32'(e_ready_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen_valid = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (e_valid_o !== 1'b0) seen_valid++;
    end
    check("rst_no_valid", 32'(seen_valid), 32'd0);
    run_op("after_rst", 3'b110, 32'hFFFF_FF00, 32'd9, 0);

    // flush together with E_valid in IDLE: no capture
    E_valid_i = 1'b1; flush_i = 1'b1; funct3_i = 3'b101; src1_i = 32'd9; src2_i = 32'd0;
    tick();
    E_valid_i = 1'b0; flush_i = 1'b0;
    check("idle_flush_busy", 32'(busy_o), 32'd0);
    tick();
    check("idle_flush_valid", 32'(e_valid_o), 32'd0);

    // flush in DONE with M_ready_i: back to IDLE
    E_valid_i = 1'b1; funct3_i = 3'b101; src1_i = 32'd9; src2_i = 32'd0;
    tick();
    E_valid_i = 1'b0;
    check("done_flush_pre", 32'(e_valid_o), 32'd1);
    M_ready_i = 1'b1; flush_i = 1'b1;
    tick();
    M_ready_i = 1'b0; flush_i = 1'b0;
    check("done_flush_valid", 32'(e_valid_o), 32'd0);
    check("done_flush_ready", 32'(e_ready_o), 32'd1);

    // randomized ops against the reference model
    for (int k = 0; k < 24; k++) begin
      rf = 3'($urandom_range(0, 7));
      run_op($sformatf("rand%0d_f%0d", k, rf), rf, pick(), pick(), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exu_mdu_ctrl.md
Name: exu_mdu_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide path in the E stage.
- Accepts one M-extension op from E-pipe and iterates a shared 32-bit shift-add/restoring-subtract datapath.
- Presents the result to M-pipe using the same valid/ready handshake as the single-cycle ALU path.
- Stalls E-pipe (e_ready_o low) while busy; the single-cycle path is not involved.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width; log2(XLEN).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- E_valid_i  input  1  E-pipe holds a valid MDU op.
- e_ready_o  output  1  block can accept an op this cycle.
- e_valid_o  output  1  result valid to M-pipe.
- M_ready_i  input  1  M-pipe accepts the result.
- flush_i  input  1  kill the in-flight op (branch/trap redirect).
- funct3_i  input  3  000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
- src1_i  input  XLEN  rs1 operand.
- src2_i  input  XLEN  rs2 operand.
- res_o  output  XLEN  result; stable while e_valid_o=1.
- busy_o  output  1  state != IDLE.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, cnt=0, e_valid_o=0, res_o=0, busy_o=0, e_ready_o=1. Internal accumulators are cleared.
- States and transitions:
  - IDLE: e_ready_o=1. On E_valid_i && !flush_i, capture funct3 and operands.
    - Special divide case: next state DONE.
    - Otherwise: next state CALC, cnt=0.
  - CALC: e_ready_o=0. One iteration per cycle. When cnt==XLEN-1, next state FIX; else cnt+1.
  - FIX: apply sign correction and select the result word into res_o. Next state DONE.
  - DONE: e_valid_o=1, e_ready_o=0. When M_ready_i, next state IDLE. No new accept in the same cycle.
- Latency: accept at edge T, so e_valid_o is high in the cycle after edge T+XLEN+1 (34 clocks for XLEN=32). Special divide cases give e_valid_o after edge T+1.
- Signedness:
  - Signed operands are converted to magnitude at capture: mulh both signed; mulhsu rs1 only; div/rem both.
  - Result negation in FIX:
    - product: sign = s1 xor s2;
    - quotient: sign = s1 xor s2;
    - remainder: takes the dividend's sign.
- Multiply:
  - 2*XLEN accumulator, add-shift on the multiplier LSB.
  - mul returns the low XLEN bits; mulh/mulhsu/mulhu return the high XLEN bits of the signed-corrected product.
- Divide: restoring, one quotient bit per cycle, MSB first.
- Special divide cases (decided in IDLE, no iteration):
  - divisor==0: div/divu = all ones; rem/remu = src1.
  - Signed overflow (src1=0x80000000, src2=0xFFFFFFFF, div/rem): div = 0x80000000; rem = 0.
- Handshake:
  - e_valid_o stays high and res_o is held until M_ready_i.
  - e_valid_o does not depend combinationally on M_ready_i.
- Flush:
  - In any state, flush_i forces next state IDLE and cnt=0; the result is discarded.
  - flush_i in DONE with M_ready_i=1: flush wins, but the transfer has already occurred this cycle.
  - flush_i with E_valid_i in IDLE: no capture.
- Reset mid-operation: immediate return to the reset values above; no result is produced.

Test Plan:
- mulhu src1=0xFFFFFFFF, src2=0xFFFFFFFF, M_ready_i=1 -> e_valid_o rises exactly 34 cycles after accept; res_o=0xFFFFFFFE; e_ready_o low throughout.
- mulh src1=0xFFFFFFFE(-2), src2=3; then mul same operands -> mulh res_o=0xFFFFFFFF; mul res_o=0xFFFFFFFA.
- div src1=-7, src2=2; rem same operands -> div res_o=0xFFFFFFFD(-3); rem res_o=0xFFFFFFFF(-1).
- divu src1=5, src2=0; then div src1=0x80000000, src2=0xFFFFFFFF -> divu res_o=0xFFFFFFFF and div res_o=0x80000000, each valid 1 cycle after accept.
- Back-pressure: hold M_ready_i=0 for 10 cycles in DONE -> e_valid_o=1 and res_o constant; release gives one transfer, then IDLE with e_ready_o=1 the next cycle.
- flush_i pulsed at cnt=10 during div, and rst_n pulsed low mid-CALC -> both cases return to IDLE with e_valid_o never asserted; the next op's result is correct.
